// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-side responder: MMIO word offsets inside the
// 16-word window, TMR_CTRL bit positions and the timer FSM state type.
package dmem_pkg;

    // Word offsets within the MMIO window (daddr[3:0])
    localparam logic [3:0] OFS_GPIO_OUT = 4'd0;
    localparam logic [3:0] OFS_GPIO_IN  = 4'd1;
    localparam logic [3:0] OFS_CYCLE    = 4'd2;
    localparam logic [3:0] OFS_TMR_CMP  = 4'd3;
    localparam logic [3:0] OFS_TMR_CTRL = 4'd4;
    localparam logic [3:0] OFS_TMR_CNT  = 4'd5;

    // TMR_CTRL bit indices
    localparam int CTRL_EN   = 0;
    localparam int CTRL_FLAG = 1;
    localparam int CTRL_AUTO = 2;

    typedef enum logic {
        TMR_IDLE,
        TMR_RUN
    } tmr_state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Word-addressed load/store bus between the RV32 core (master) and the data
// memory responder (slave).
//   daddr   : word address
//   ddata_w : store data
//   d_w     : store strobe (whole word)
//   d_r     : load strobe
//   ddata_r : load data, combinational from daddr/d_r
interface data_mem_responder_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] daddr;
    logic [31:0]       ddata_w;
    logic              d_w;
    logic              d_r;
    logic [31:0]       ddata_r;

    modport master (
        output daddr, ddata_w, d_w, d_r,
        input  ddata_r
    );

    modport slave (
        input  daddr, ddata_w, d_w, d_r,
        output ddata_r
    );
endinterface

// File: rtl/data_mem_responder_mmio_timer.sv
// Compare timer block of the MMIO window: TMR_CMP, TMR_CTRL and TMR_CNT
// registers, the IDLE/RUN FSM and the level irq.
//   CLK, RSTn  : clock, asynchronous active-low reset
//   cmp_we     : write strobe for TMR_CMP
//   ctrl_we    : write strobe for TMR_CTRL
//   cnt_we     : write strobe for TMR_CNT
//   wdata      : store data from the bus
//   tmr_cmp    : TMR_CMP value
//   tmr_ctrl   : TMR_CTRL read value {AUTO, FLAG, EN}, upper bits zero
//   tmr_cnt    : TMR_CNT value
//   irq        : FLAG, straight from its flop
module mmio_timer
    import dmem_pkg::*;
(
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        cmp_we,
    input  logic        ctrl_we,
    input  logic        cnt_we,
    input  logic [31:0] wdata,
    output logic [31:0] tmr_cmp,
    output logic [31:0] tmr_ctrl,
    output logic [31:0] tmr_cnt,
    output logic        irq
);

    tmr_state_t  state;
    logic [31:0] cmp_q;
    logic [31:0] cnt_q;
    logic        flag_q;
    logic        auto_q;
    logic        match;

    // Match uses the pre-write CNT/CMP so a same-cycle software write cannot
    // hide an event that the old count had already reached.
    assign match = (state == TMR_RUN) && (cnt_q == cmp_q);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state  <= TMR_IDLE;
            cmp_q  <= '0;
            cnt_q  <= '0;
            flag_q <= 1'b0;
            auto_q <= 1'b0;
        end else begin
            if (cmp_we)
                cmp_q <= wdata;

            if (ctrl_we)
                auto_q <= wdata[CTRL_AUTO];

            // A new match beats a W1C in the same cycle.
            if (match)
                flag_q <= 1'b1;
            else if (ctrl_we && wdata[CTRL_FLAG])
                flag_q <= 1'b0;

            // Software write to CNT overrides whatever the timer would do.
            if (cnt_we)
                cnt_q <= wdata;
            else if (state == TMR_RUN) begin
                if (!match)
                    cnt_q <= cnt_q + 32'd1;
                else if (auto_q)
                    cnt_q <= '0;
            end

            // Written EN beats the one-shot stop on a match.
            if (ctrl_we)
                state <= wdata[CTRL_EN] ? TMR_RUN : TMR_IDLE;
            else if (match && !auto_q)
                state <= TMR_IDLE;
        end
    end

    assign tmr_cmp  = cmp_q;
    assign tmr_cnt  = cnt_q;
    assign tmr_ctrl = {29'd0, auto_q, flag_q, (state == TMR_RUN)};
    assign irq      = flag_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-side responder for the single-cycle RV32 core. Word-addressed data RAM
// with a 16-word MMIO window (GPIO, cycle counter, compare timer) shadowing the
// top of the map. Loads are combinational, stores commit on the CLK edge.
//   CLK, RSTn : clock, asynchronous active-low reset (RAM contents not reset)
//   bus       : slave side of the core load/store bus
//   gpio_in   : external inputs, asynchronous to CLK
//   gpio_out  : GPIO_OUT register
//   irq       : timer match flag (level)
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] MMIO_BASE = 10'h3F0,
    parameter int                GPIO_W    = 8
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    data_mem_responder_if.slave  bus,
    input  logic [GPIO_W-1:0]    gpio_in,
    output logic [GPIO_W-1:0]    gpio_out,
    output logic                 irq
);

    logic [31:0]       ram [2**ADDR_W];
    logic              mmio_sel;
    logic [3:0]        ofs;
    logic              mmio_we;
    logic [GPIO_W-1:0] gpio_s1;
    logic [GPIO_W-1:0] gpio_s2;
    logic [31:0]       cycle_q;
    logic [31:0]       tmr_cmp;
    logic [31:0]       tmr_ctrl;
    logic [31:0]       tmr_cnt;
    logic [31:0]       rdata;

    assign mmio_sel = (bus.daddr[ADDR_W-1:4] == MMIO_BASE[ADDR_W-1:4]);
    assign ofs      = bus.daddr[3:0];
    assign mmio_we  = bus.d_w && mmio_sel;

    // RAM has no reset; stores are suppressed while RSTn is low and for
    // addresses under the MMIO window.
    always_ff @(posedge CLK) begin
        if (RSTn && bus.d_w && !mmio_sel)
            ram[bus.daddr] <= bus.ddata_w;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            gpio_out <= '0;
            gpio_s1  <= '0;
            gpio_s2  <= '0;
            cycle_q  <= '0;
        end else begin
            if (mmio_we && ofs == OFS_GPIO_OUT)
                gpio_out <= bus.ddata_w[GPIO_W-1:0];
            gpio_s1 <= gpio_in;
            gpio_s2 <= gpio_s1;
            cycle_q <= cycle_q + 32'd1;
        end
    end

    mmio_timer u_timer (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .cmp_we   (mmio_we && ofs == OFS_TMR_CMP),
        .ctrl_we  (mmio_we && ofs == OFS_TMR_CTRL),
        .cnt_we   (mmio_we && ofs == OFS_TMR_CNT),
        .wdata    (bus.ddata_w),
        .tmr_cmp  (tmr_cmp),
        .tmr_ctrl (tmr_ctrl),
        .tmr_cnt  (tmr_cnt),
        .irq      (irq)
    );

    // Read mux reflects pre-edge state, so a same-cycle store is not visible.
    always_comb begin
        rdata = '0;
        if (bus.d_r) begin
            if (mmio_sel) begin
                case (ofs)
                    OFS_GPIO_OUT: rdata = 32'(gpio_out);
                    OFS_GPIO_IN:  rdata = 32'(gpio_s2);
                    OFS_CYCLE:    rdata = cycle_q;
                    OFS_TMR_CMP:  rdata = tmr_cmp;
                    OFS_TMR_CTRL: rdata = tmr_ctrl;
                    OFS_TMR_CNT:  rdata = tmr_cnt;
                    default:      rdata = '0;
                endcase
            end else begin
                rdata = ram[bus.daddr];
            end
        end
    end

    assign bus.ddata_r = rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
    import dmem_pkg::*;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic [7:0] gpio_in = '0;
    logic [7:0] gpio_out;
    logic       irq;

    data_mem_responder_if #(.ADDR_W(10)) bus ();

    data_mem_responder #(
        .ADDR_W    (10),
        .MMIO_BASE (10'h3F0),
        .GPIO_W    (8)
    ) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .bus      (bus),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .irq      (irq)
    );

    always #5 CLK = ~CLK;

    // kind: 0 = ddata_r, 1 = gpio_out, 2 = irq
    typedef struct {
        int          kind;
        string       nm;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    logic chk = 1'b0;
    int   total = 0;
    int   bad = 0;

    // Monitor: compares every queued expectation while chk marks a valid cycle.
    always @(negedge CLK) begin
        if (chk) begin
            while (sb.size() > 0) begin
                exp_t        e;
                logic [31:0] act;
                e = sb.pop_front();
                case (e.kind)
                    0:       act = bus.ddata_r;
                    1:       act = {24'd0, gpio_out};
                    default: act = {31'd0, irq};
                endcase
                total++;
                if (act !== e.exp) begin
                    bad++;
                    $display("FAIL %s: got 0x%08h want 0x%08h at %0t", e.nm, act, e.exp, $time);
                end
            end
        end
    end

    task automatic expect_v(input int kind, input string nm, input logic [31:0] v);
        exp_t e;
        e.kind = kind;
        e.nm   = nm;
        e.exp  = v;
        sb.push_back(e);
        chk = 1'b1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        chk         = 1'b0;
        bus.d_w     = 1'b0;
        bus.d_r     = 1'b0;
        bus.ddata_w = '0;
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        bus.daddr   = a;
        bus.ddata_w = d;
        bus.d_w     = 1'b1;
        tick();
    endtask

    task automatic rd(input logic [9:0] a, input logic [31:0] v, input string nm);
        bus.daddr = a;
        bus.d_r   = 1'b1;
        expect_v(0, nm, v);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.daddr   = '0;
        bus.ddata_w = '0;
        bus.d_w     = 1'b0;
        bus.d_r     = 1'b0;
        @(posedge CLK);
        #1;

        // Reset state
        expect_v(1, "rst_gpio_out", 32'd0);
        expect_v(2, "rst_irq", 32'd0);
        expect_v(0, "rst_dr0", 32'd0);
        tick();
        rd(10'h3F4, 32'd0, "rst_ctrl");
        RSTn = 1'b1;

        // CYCLE: 5 edges after release, then 10 more
        repeat (5) tick();
        rd(10'h3F2, 32'd5, "cycle_5");
        repeat (9) tick();
        rd(10'h3F2, 32'd15, "cycle_15");

        // RAM store / load
        wr(10'h010, 32'hDEADBEEF);
        rd(10'h010, 32'hDEADBEEF, "ram_rd");
        bus.daddr = 10'h010;
        expect_v(0, "ram_dr0", 32'd0);
        tick();

        // GPIO out and synchronised in
        wr(10'h3F0, 32'h000000A5);
        expect_v(1, "gpio_out_a5", 32'hA5);
        tick();
        wr(10'h3F0, 32'hFFFFFF5A);
        rd(10'h3F0, 32'h5A, "gpio_out_rd");
        gpio_in = 8'h3C;
        rd(10'h3F1, 32'd0, "gpio_in_0");
        rd(10'h3F1, 32'd0, "gpio_in_1");
        rd(10'h3F1, 32'h3C, "gpio_in_2");
        rd(10'h3F9, 32'd0, "unmapped");

        // One-shot timer
        wr(10'h3F3, 32'd3);
        wr(10'h3F4, 32'b001);
        rd(10'h3F5, 32'd0, "os_cnt0");
        rd(10'h3F5, 32'd1, "os_cnt1");
        rd(10'h3F5, 32'd2, "os_cnt2");
        expect_v(2, "os_irq_pre", 32'd0);
        rd(10'h3F5, 32'd3, "os_cnt3");
        expect_v(2, "os_irq", 32'd1);
        rd(10'h3F4, 32'b010, "os_ctrl");
        rd(10'h3F5, 32'd3, "os_cnt_hold");
        wr(10'h3F4, 32'b010);
        expect_v(2, "os_irq_clr", 32'd0);
        rd(10'h3F4, 32'd0, "os_ctrl_clr");

        // Auto-reload timer
        wr(10'h3F3, 32'd2);
        wr(10'h3F5, 32'd0);
        wr(10'h3F4, 32'b101);
        rd(10'h3F5, 32'd0, "ar_cnt0");
        rd(10'h3F5, 32'd1, "ar_cnt1");
        expect_v(2, "ar_irq_pre", 32'd0);
        rd(10'h3F5, 32'd2, "ar_cnt2");
        expect_v(2, "ar_irq", 32'd1);
        rd(10'h3F5, 32'd0, "ar_cnt0b");
        rd(10'h3F5, 32'd1, "ar_cnt1b");
        // W1C on a match cycle: set wins
        bus.daddr   = 10'h3F4;
        bus.ddata_w = 32'b111;
        bus.d_w     = 1'b1;
        bus.d_r     = 1'b1;
        expect_v(0, "ar_ctrl_pre", 32'b111);
        tick();
        expect_v(2, "ar_w1c_match", 32'd1);
        rd(10'h3F5, 32'd0, "ar_cnt0c");
        wr(10'h3F4, 32'b111);
        expect_v(2, "ar_w1c", 32'd0);
        rd(10'h3F5, 32'd2, "ar_cnt2c");
        // FLAG bit 0 in a CTRL write leaves FLAG alone
        wr(10'h3F4, 32'd0);
        expect_v(2, "ar_flag_keep", 32'd1);
        rd(10'h3F4, 32'b010, "ar_ctrl_stop");
        wr(10'h3F4, 32'b010);

        // Store and load same cycle
        wr(10'h020, 32'h1);
        bus.daddr   = 10'h020;
        bus.ddata_w = 32'h2;
        bus.d_w     = 1'b1;
        bus.d_r     = 1'b1;
        expect_v(0, "rw_old", 32'h1);
        tick();
        rd(10'h020, 32'h2, "rw_new");

        // Reset mid-run
        wr(10'h030, 32'h11);
        wr(10'h3F3, 32'd3);
        wr(10'h3F5, 32'd0);
        wr(10'h3F4, 32'b101);
        repeat (5) tick();
        expect_v(2, "mr_irq_on", 32'd1);
        tick();
        RSTn = 1'b0;
        bus.daddr   = 10'h030;
        bus.ddata_w = 32'h55;
        bus.d_w     = 1'b1;
        expect_v(2, "mr_irq_rst", 32'd0);
        expect_v(1, "mr_gpio_rst", 32'd0);
        tick();
        rd(10'h3F5, 32'd0, "mr_cnt_rst");
        RSTn = 1'b1;
        tick();
        rd(10'h3F4, 32'd0, "mr_ctrl");
        rd(10'h3F5, 32'd0, "mr_cnt_idle");
        rd(10'h030, 32'h11, "mr_ram_kept");

        // CYCLE wrap
        force dut.cycle_q = 32'hFFFFFFFF;
        #1;
        release dut.cycle_q;
        rd(10'h3F2, 32'hFFFFFFFF, "cycle_max");
        rd(10'h3F2, 32'd0, "cycle_wrap");

        @(negedge CLK);
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_drain: got %0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
